// File: rtl/laser_safety_sequencer.sv
// Laser supply / amplifier safety sequencer.
// Arms on request, waits for settled power-good, supervises RUN, latches faults.
module laser_safety_sequencer #(
  parameter int PG_SETTLE_CYCLES    = 25000,
  parameter int PG_TIMEOUT_CYCLES   = 250000,
  parameter int WDOG_TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable_req,
  input  logic       pwr_good,
  input  logic [3:0] limit_fail,
  input  logic       current_fail,
  input  logic       wdog_kick,
  input  logic       clear_fail,
  output logic       laser_pwr_en,
  output logic       ta_shutdown,
  output logic [7:0] fault_latch,
  output logic [1:0] state
);

  localparam int SW = (PG_SETTLE_CYCLES > 1) ?
                      $clog2(PG_SETTLE_CYCLES) : 1;
  localparam int TW = (PG_TIMEOUT_CYCLES > 1) ?
                      $clog2(PG_TIMEOUT_CYCLES) : 1;
  localparam int WW = (WDOG_TIMEOUT_CYCLES > 1) ?
                      $clog2(WDOG_TIMEOUT_CYCLES) : 1;

  localparam logic [SW-1:0] SETTLE_MAX =
    SW'(PG_SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX =
    TW'(PG_TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_MAX =
    WW'(WDOG_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PG_WAIT = 2'd1,
    RUN     = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t cur, nxt;

  logic [1:0]    pg_sync;
  logic          pg_s;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] wdog_cnt;

  logic       any_fault;
  logic [4:0] fault_bits;
  logic       settle_hit;
  logic       pg_tmo;
  logic       wdog_exp;
  logic [7:0] latch_set;
  logic       latch_clr;
  logic       pwr_en_nxt;
  logic       shut_nxt;

  assign pg_s       = pg_sync[1];
  assign fault_bits = {current_fail, limit_fail};
  assign any_fault  = |fault_bits;
  // Counters hit their last value on the cycle the event fires.
  assign settle_hit = pg_s && (settle_cnt == SETTLE_MAX);
  assign pg_tmo     = (tmo_cnt == TMO_MAX);
  assign wdog_exp   = (wdog_cnt == WDOG_MAX) && !wdog_kick;
  assign state      = cur;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur          <= IDLE;
      pg_sync      <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      wdog_cnt     <= '0;
      fault_latch  <= '0;
      laser_pwr_en <= 1'b0;
      ta_shutdown  <= 1'b1;
    end else begin
      cur          <= nxt;
      pg_sync      <= {pg_sync[0], pwr_good};
      laser_pwr_en <= pwr_en_nxt;
      ta_shutdown  <= shut_nxt;
      fault_latch  <= latch_clr ? '0 :
                      (fault_latch | latch_set);
      if (cur == PG_WAIT) begin
        if (!pg_s)
          settle_cnt <= '0;
        else if (settle_cnt != SETTLE_MAX)
          settle_cnt <= settle_cnt + 1'b1;
        if (tmo_cnt != TMO_MAX)
          tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
        tmo_cnt    <= '0;
      end
      if (cur == RUN) begin
        if (wdog_kick)
          wdog_cnt <= '0;
        else if (wdog_cnt != WDOG_MAX)
          wdog_cnt <= wdog_cnt + 1'b1;
      end else begin
        wdog_cnt <= '0;
      end
    end
  end

  always_comb begin
    nxt       = cur;
    latch_set = '0;
    latch_clr = 1'b0;
    unique case (cur)
      IDLE: begin
        if (enable_req && !any_fault)
          nxt = PG_WAIT;
      end
      PG_WAIT: begin
        if (any_fault || pg_tmo) begin
          nxt            = FAULT;
          latch_set[4:0] = fault_bits;
          latch_set[7]   = pg_tmo;
        end else if (!enable_req) begin
          nxt = IDLE;
        end else if (settle_hit) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (any_fault || wdog_exp || !pg_s) begin
          nxt            = FAULT;
          latch_set[4:0] = fault_bits;
          latch_set[5]   = wdog_exp;
          latch_set[6]   = !pg_s;
        end else if (!enable_req) begin
          nxt = IDLE;
        end
      end
      FAULT: begin
        latch_set[4:0] = fault_bits;
        if (clear_fail && !any_fault) begin
          nxt       = IDLE;
          latch_clr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    pwr_en_nxt = (nxt == PG_WAIT) || (nxt == RUN);
    shut_nxt   = (nxt != RUN);
  end

endmodule

// File: tb/tb_laser_safety_sequencer.sv
// Directed bench for laser_safety_sequencer.
// Small parameters; expected values worked out by hand per cycle.
module tb_laser_safety_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable_req;
  logic       pwr_good;
  logic [3:0] limit_fail;
  logic       current_fail;
  logic       wdog_kick;
  logic       clear_fail;
  logic       laser_pwr_en;
  logic       ta_shutdown;
  logic [7:0] fault_latch;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  laser_safety_sequencer #(
    .PG_SETTLE_CYCLES   (4),
    .PG_TIMEOUT_CYCLES  (16),
    .WDOG_TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable_req  (enable_req),
    .pwr_good    (pwr_good),
    .limit_fail  (limit_fail),
    .current_fail(current_fail),
    .wdog_kick   (wdog_kick),
    .clear_fail  (clear_fail),
    .laser_pwr_en(laser_pwr_en),
    .ta_shutdown (ta_shutdown),
    .fault_latch (fault_latch),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [1:0] st,
                         input logic pe,
                         input logic sd,
                         input logic [7:0] fl);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".pwr_en"}, 32'(laser_pwr_en), 32'(pe));
    chk({tag, ".shutdown"}, 32'(ta_shutdown), 32'(sd));
    chk({tag, ".latch"}, 32'(fault_latch), 32'(fl));
  endtask

  // Requires pwr_good already synchronized high.
  task automatic arm(input string tag);
    enable_req = 1'b1;
    tick(1);
    chk_out({tag, ".pgw"}, 2'd1, 1'b1, 1'b1, 8'h00);
    tick(3);
    chk({tag, ".still_pgw"}, 32'(state), 32'd1);
    tick(1);
    chk_out({tag, ".run"}, 2'd2, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_clear(input string tag);
    enable_req = 1'b0;
    clear_fail = 1'b1;
    tick(1);
    clear_fail = 1'b0;
    chk_out({tag, ".cleared"}, 2'd0, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    rstn         = 1'b0;
    enable_req   = 1'b0;
    pwr_good     = 1'b0;
    limit_fail   = 4'b0;
    current_fail = 1'b0;
    wdog_kick    = 1'b0;
    clear_fail   = 1'b0;
    tick(2);
    chk_out("reset", 2'd0, 1'b0, 1'b1, 8'h00);
    rstn = 1'b1;
    tick(3);
    chk_out("post_reset_idle", 2'd0, 1'b0, 1'b1, 8'h00);

    // Arm from cold: 1 edge to PG_WAIT, 2 sync, 4 settle.
    enable_req = 1'b1;
    pwr_good   = 1'b1;
    tick(1);
    chk_out("arm.pgw", 2'd1, 1'b1, 1'b1, 8'h00);
    tick(4);
    chk("arm.still_pgw", 32'(state), 32'd1);
    tick(1);
    chk_out("arm.run", 2'd2, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 3; i++) begin
      tick(6);
      wdog_kick = 1'b1;
      tick(1);
      wdog_kick = 1'b0;
    end
    chk("wdog.kick7", 32'(state), 32'd2);
    tick(7);
    wdog_kick = 1'b1;
    tick(1);
    wdog_kick = 1'b0;
    chk("wdog.kick_on_expiry", 32'(state), 32'd2);
    tick(7);
    chk("wdog.before_expiry", 32'(state), 32'd2);
    tick(1);
    chk_out("wdog.fault", 2'd3, 1'b0, 1'b1, 8'h20);
    do_clear("wdog");

    arm("lim");
    limit_fail = 4'b0100;
    tick(1);
    limit_fail = 4'b0000;
    chk_out("lim.fault", 2'd3, 1'b0, 1'b1, 8'h04);
    tick(2);
    chk("lim.sticky", 32'(fault_latch), 32'h04);
    do_clear("lim");

    arm("cur");
    current_fail = 1'b1;
    tick(1);
    chk_out("cur.fault", 2'd3, 1'b0, 1'b1, 8'h10);
    clear_fail = 1'b1;
    tick(1);
    clear_fail = 1'b0;
    chk_out("cur.clear_ignored", 2'd3, 1'b0, 1'b1, 8'h10);
    current_fail = 1'b0;
    do_clear("cur");

    // A fault input in IDLE blocks arming and latches nothing.
    enable_req = 1'b1;
    limit_fail = 4'b0001;
    tick(2);
    chk_out("idle_block", 2'd0, 1'b0, 1'b1, 8'h00);
    limit_fail = 4'b0000;
    enable_req = 1'b0;
    tick(1);

    // Power-good never comes: timeout 16 edges after entry.
    pwr_good   = 1'b0;
    enable_req = 1'b1;
    tick(1);
    chk("tmo.pgw", 32'(state), 32'd1);
    tick(15);
    chk("tmo.before", 32'(state), 32'd1);
    tick(1);
    chk_out("tmo.fault", 2'd3, 1'b0, 1'b1, 8'h80);
    pwr_good = 1'b1;
    do_clear("tmo");
    tick(3);

    arm("pgl");
    pwr_good = 1'b0;
    tick(2);
    chk("pgl.sync_delay", 32'(state), 32'd2);
    tick(1);
    chk_out("pgl.fault", 2'd3, 1'b0, 1'b1, 8'h40);
    pwr_good = 1'b1;
    do_clear("pgl");
    tick(3);

    arm("drop");
    enable_req = 1'b0;
    tick(1);
    chk_out("drop.idle", 2'd0, 1'b0, 1'b1, 8'h00);

    // Fault outranks enable drop in the same cycle.
    arm("prio");
    enable_req   = 1'b0;
    current_fail = 1'b1;
    limit_fail   = 4'b1001;
    tick(1);
    current_fail = 1'b0;
    limit_fail   = 4'b0000;
    chk_out("prio.fault", 2'd3, 1'b0, 1'b1, 8'h19);
    do_clear("prio");
    tick(1);

    arm("rst");
    rstn = 1'b0;
    tick(1);
    chk_out("rst.mid_run", 2'd0, 1'b0, 1'b1, 8'h00);
    rstn = 1'b1;
    tick(1);
    chk("rst.rearm_pgw", 32'(state), 32'd1);
    tick(4);
    chk("rst.sync_cleared", 32'(state), 32'd1);
    tick(1);
    chk("rst.run", 32'(state), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
